imem_loadable: RTL and testbench

// - Parametrised instruction memory for the RV32I core, loadable at runtime.
// - A word-stream load port (valid/ready) fills the memory after reset.
// - Replaces the fixed hex-file ROM. Holds the core until a program is loaded.
// - Fetch port: byte address in, 32-bit instruction out; combinational or registered.

---
 rtl/imem_loadable.sv | 182 ++++++++++++++++++
 tb/tb_imem_loadable.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Runtime-loadable instruction memory: a word-stream load port fills it, then it serves fetches.
// Optional build macro IMEM_LOAD_CKSUM_EN: the final load beat is a sum-of-words checksum instead of data.
module imem_loadable #(
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 1024,
  parameter int          READ_LAT = 0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  output logic              core_hold_o,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              fetch_fault_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            ld_err_q, ld_err_d;
  logic            mem_we_s;
  logic            beat_s;
  logic            run_s;
  logic [31:0]     mem_q [DEPTH];
`ifdef IMEM_LOAD_CKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  assign beat_s      = ld_valid_i && (state_q == ST_LOAD);
  assign run_s       = (state_q == ST_RUN);
  assign ld_ready_o  = (state_q == ST_LOAD);
  assign ld_done_o   = run_s;
  assign core_hold_o = !run_s;
  assign ld_err_o    = ld_err_q;

  // Load-control state, write pointer and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      ld_err_q <= 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
      sum_q    <= 32'h0000_0000;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      ld_err_q <= ld_err_d;
`ifdef IMEM_LOAD_CKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // Next-state: start/restart a load, accept beats, detect end or overflow
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    ld_err_d = ld_err_q;
    mem_we_s = 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ld_start_i) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          ld_err_d = 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
          sum_d    = 32'h0000_0000;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (beat_s) begin
`ifdef IMEM_LOAD_CKSUM_EN
          if (ld_last_i) begin
            if (sum_q == ld_data_i) begin
              state_d = ST_RUN;
            end else begin
              state_d  = ST_IDLE;
              ld_err_d = 1'b1;
            end
          end else if (wr_ptr_q == PW'(DEPTH)) begin
            // memory already full: the extra data beat is dropped
            state_d  = ST_IDLE;
            ld_err_d = 1'b1;
          end else begin
            mem_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            sum_d    = sum_q + ld_data_i;
          end
`else
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
          if (ld_last_i) begin
            state_d = ST_RUN;
          end else if (wr_ptr_q == PW'(DEPTH - 1)) begin
            // last slot filled but the program claims more words
            state_d  = ST_IDLE;
            ld_err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[IW-1:0]] <= ld_data_i;
    end
  end

  logic [ADDR_W-1:0] word_s;
  logic [IW-1:0]     idx_s;
  logic              fault_s;
  logic [31:0]       rd_word_s;

  assign word_s    = fetch_addr_i >> 2;
  assign idx_s     = fetch_addr_i[IW+1:2];
  assign fault_s   = (fetch_addr_i[1:0] != 2'b00) || (word_s >= ADDR_W'(DEPTH));
  assign rd_word_s = fault_s ? NOP_INST : mem_q[idx_s];

  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign inst_o        = run_s ? rd_word_s : NOP_INST;
      assign inst_valid_o  = run_s && fetch_req_i;
      assign fetch_fault_o = run_s && fetch_req_i && fault_s;
    end else begin : g_reg_read
      logic [31:0] inst_q;
      logic        valid_q;
      logic        fault_q;

      // One-cycle fetch pipeline; squashed at the output once RUN is left
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          inst_q  <= NOP_INST;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
        end else begin
          inst_q  <= rd_word_s;
          valid_q <= run_s && fetch_req_i;
          fault_q <= run_s && fetch_req_i && fault_s;
        end
      end

      assign inst_valid_o  = valid_q && run_s;
      assign inst_o        = (valid_q && run_s) ? inst_q : NOP_INST;
      assign fetch_fault_o = fault_q && run_s;
    end
  endgenerate

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: two DEPTH=4 instances (combinational and registered read)
// share stimulus and are checked against a word-array reference model.
module tb_imem_loadable;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last, fetch_req;
  logic [31:0] ld_data, fetch_addr;

  logic        rdy0, done0, err0, hold0, iv0, ff0;
  logic        rdy1, done1, err1, hold1, iv1, ff1;
  logic [31:0] inst0, inst1;

  imem_loadable #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(0), .NOP_INST(NOP)) u0 (
    .clk(clk), .rst(rst), .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_last_i(ld_last), .ld_ready_o(rdy0), .ld_done_o(done0), .ld_err_o(err0),
    .core_hold_o(hold0), .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .inst_o(inst0), .inst_valid_o(iv0), .fetch_fault_o(ff0));

  imem_loadable #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(1), .NOP_INST(NOP)) u1 (
    .clk(clk), .rst(rst), .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_last_i(ld_last), .ld_ready_o(rdy1), .ld_done_o(done1), .ld_err_o(err1),
    .core_hold_o(hold1), .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .inst_o(inst1), .inst_valid_o(iv1), .fetch_fault_o(ff1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_run, m_err, m_loading;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] m_inst(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (!m_run || m_fault(a)) return NOP;
    return m_mem[w];
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, " done0"}, {31'b0, done0}, {31'b0, m_run});
    chk({tag, " hold0"}, {31'b0, hold0}, {31'b0, !m_run});
    chk({tag, " err0"},  {31'b0, err0},  {31'b0, m_err});
    chk({tag, " rdy0"},  {31'b0, rdy0},  {31'b0, m_loading});
    chk({tag, " done1"}, {31'b0, done1}, {31'b0, m_run});
    chk({tag, " err1"},  {31'b0, err1},  {31'b0, m_err});
  endtask

  // Loads the given data words. with_last=0 sends them all without a last flag (overflow case).
  // In checksum builds a checksum beat (sum, plus 1 if bad_ck) follows the data when with_last=1.
  task automatic load(input logic [31:0] w[$], input bit with_last, input bit bad_ck);
    logic [31:0] sum;
    sum = 32'h0000_0000;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    m_loading = 1'b1; m_run = 1'b0; m_err = 1'b0;
    chk_status("start");
    for (int i = 0; i < w.size(); i++) begin
      if ($urandom_range(0, 3) == 0) step();
      ld_valid = 1'b1;
      ld_data  = w[i];
      ld_start = 1'($urandom_range(0, 1));
`ifdef IMEM_LOAD_CKSUM_EN
      ld_last  = 1'b0;
`else
      ld_last  = with_last && (i == w.size() - 1);
`endif
      step();
      if (i < DEPTH) m_mem[i] = w[i];
      sum = sum + w[i];
      ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    end
`ifdef IMEM_LOAD_CKSUM_EN
    if (with_last) begin
      ld_valid = 1'b1;
      ld_data  = sum + {31'b0, bad_ck};
      ld_last  = 1'b1;
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
    end
`endif
    m_loading = 1'b0;
    m_run = with_last && !bad_ck;
    m_err = !m_run;
    chk_status("loaded");
  endtask

  // Issues back-to-back fetches; u0 is checked same cycle, u1 one cycle later.
  task automatic fetch_burst(input logic [31:0] a[$]);
    logic [31:0] prev;
    prev = 32'h0;
    for (int k = 0; k < a.size(); k++) begin
      fetch_req  = 1'b1;
      fetch_addr = a[k];
      #1;
      chk("u0 inst",  inst0, m_inst(a[k]));
      chk("u0 valid", {31'b0, iv0}, {31'b0, m_run});
      chk("u0 fault", {31'b0, ff0}, {31'b0, m_run && m_fault(a[k])});
      if (k > 0) begin
        chk("u1 inst",  inst1, m_inst(prev));
        chk("u1 valid", {31'b0, iv1}, {31'b0, m_run});
        chk("u1 fault", {31'b0, ff1}, {31'b0, m_run && m_fault(prev)});
      end else begin
        chk("u1 idle valid", {31'b0, iv1}, 32'h0);
      end
      prev = a[k];
      step();
    end
    fetch_req = 1'b0;
    #1;
    chk("u0 valid off", {31'b0, iv0}, 32'h0);
    chk("u1 inst",  inst1, m_inst(prev));
    chk("u1 valid", {31'b0, iv1}, {31'b0, m_run});
    chk("u1 fault", {31'b0, ff1}, {31'b0, m_run && m_fault(prev)});
    step();
    chk("u1 valid off", {31'b0, iv1}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] addrs[$];
    int n;

    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'h0;
    fetch_req = 1'b0; fetch_addr = 32'h0;
    m_run = 1'b0; m_err = 1'b0; m_loading = 1'b0;
    #2;
    chk("rst hold0", {31'b0, hold0}, 32'h1);
    chk("rst hold1", {31'b0, hold1}, 32'h1);
    chk("rst rdy0",  {31'b0, rdy0},  32'h0);
    chk("rst inst0", inst0, NOP);
    chk("rst inst1", inst1, NOP);
    chk("rst iv1",   {31'b0, iv1},   32'h0);
    #20;
    rst = 1'b0;
    step();
    chk_status("idle");

    // Fetch before any program is loaded
    fetch_burst('{32'h0, 32'h2});

    prog = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};
    load(prog, 1'b1, 1'b0);
    fetch_burst('{32'h0, 32'h4, 32'h8, 32'hC});
    fetch_burst('{32'h2, 32'(4 * DEPTH), 32'h4, 32'hFFFF_FFFC});

    // Restart while a registered fetch is in flight
    fetch_req = 1'b1; fetch_addr = 32'h4; ld_start = 1'b1;
    #1;
    chk("sq u0 valid", {31'b0, iv0}, 32'h1);
    step();
    fetch_req = 1'b0; ld_start = 1'b0;
    m_run = 1'b0; m_loading = 1'b1;
    chk("sq u1 valid", {31'b0, iv1}, 32'h0);
    chk("sq u1 inst",  inst1, NOP);
    chk("sq u0 valid", {31'b0, iv0}, 32'h0);
    chk_status("sq");
    load('{32'h1111_0000, 32'h2222_0004}, 1'b1, 1'b0);
    fetch_burst('{32'h4, 32'h0, 32'h8});

    // Overflow: the program never signals its final beat
`ifdef IMEM_LOAD_CKSUM_EN
    load('{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4}, 1'b0, 1'b0);
`else
    load('{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b0, 1'b0);
`endif
    chk("ovf hold1", {31'b0, hold1}, 32'h1);
    fetch_burst('{32'h0, 32'h4});

    // Reset in the middle of a load
    ld_start = 1'b1; step(); ld_start = 1'b0;
    m_err = 1'b0; m_loading = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hB0 + 32'(i); ld_last = 1'b0;
      step();
      m_mem[i] = 32'hB0 + 32'(i);
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    #2;
    m_loading = 1'b0; m_run = 1'b0;
    chk_status("midrst");
    chk("midrst hold1", {31'b0, hold1}, 32'h1);
    step();
    rst = 1'b0;
    step();
    fetch_burst('{32'h0});
    load('{32'hC0DE_0001}, 1'b1, 1'b0);
    fetch_burst('{32'h0, 32'h4, 32'h8});

`ifdef IMEM_LOAD_CKSUM_EN
    load('{32'h1, 32'h2}, 1'b1, 1'b0);
    fetch_burst('{32'h0, 32'h4});
    load('{32'h1, 32'h2}, 1'b1, 1'b1);
    chk("ck hold0", {31'b0, hold0}, 32'h1);
    fetch_burst('{32'h0});
`endif

    // Randomised loads and fetch bursts
    for (int it = 0; it < 15; it++) begin
      n = $urandom_range(1, DEPTH);
      prog = {};
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      load(prog, 1'b1, 1'b0);
      addrs = {};
      for (int k = 0; k < $urandom_range(3, 6); k++) begin
        addrs.push_back(32'($urandom_range(0, 4 * DEPTH + 7)));
      end
      fetch_burst(addrs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
